wb_pipe2std_bridge: RTL

WB_PIPE2STD_BRIDGE -- requirements
Module: wb_pipe2std_bridge

---
 rtl/wb_pkg.sv | 5 +
 rtl/wb_req_fifo.sv | 42 ++++
 rtl/wb_pipe2std_bridge.sv | 77 +++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM state type and buffer sizing constant for the Wishbone bridge
package wb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int MIN_DEPTH = 2;
endpackage

// File: rtl/wb_req_fifo.sv
// wb_req_fifo: request buffer with push/pop/flush, full/empty/last-entry flags
module wb_req_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         last
);
  localparam int AB = $clog2(DEPTH);
  localparam int CW = AB + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AB-1:0] wp, rp;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AB'(push);
      rp  <= rp + AB'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  assign dout  = mem[rp];
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign last  = cnt == CW'(1);
endmodule

// File: rtl/wb_pipe2std_bridge.sv
// wb_pipe2std_bridge: pipelined Wishbone slave to standard Wishbone master bridge.
// Define WB_BRIDGE_ERR_EN to add the m_err/s_err error-termination ports.
module wb_pipe2std_bridge
  import wb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_cyc,
  input  logic            s_stb,
  input  logic            s_we,
  input  logic [AW-1:0]   s_adr,
  input  logic [DW-1:0]   s_dat_i,
  input  logic [DW/8-1:0] s_sel,
  output logic            s_stall,
  output logic            s_ack,
  output logic [DW-1:0]   s_dat_o,
  output logic            m_cyc,
  output logic            m_stb,
  output logic            m_we,
  output logic [AW-1:0]   m_adr,
  output logic [DW-1:0]   m_dat_o,
  output logic [DW/8-1:0] m_sel,
`ifdef WB_BRIDGE_ERR_EN
  input  logic            m_err,
  output logic            s_err,
`endif
  input  logic            m_ack,
  input  logic [DW-1:0]   m_dat_i
);
  localparam int RW = 1 + AW + DW + DW / 8;
  state_t state, state_n;
  logic push, term, err_in, busy, full, empty, last;
  logic [RW-1:0] head;
`ifdef WB_BRIDGE_ERR_EN
  assign err_in = m_err;
`else
  assign err_in = 1'b0;
`endif
  // dropping s_cyc gates the master side immediately and flushes everything
  assign busy  = (state == BUSY) && s_cyc;
  assign push  = s_cyc & s_stb & !full;
  assign term  = busy & (m_ack | err_in);
  assign m_cyc = busy;
  assign m_stb = busy;
  assign s_stall = full;
  assign {m_we, m_adr, m_dat_o, m_sel} = head;
  wb_req_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(term), .flush(!s_cyc),
    .din({s_we, s_adr, s_dat_i, s_sel}), .dout(head),
    .full(full), .empty(empty), .last(last)
  );
  // counting the incoming push lets a fresh request reach m_stb on the next cycle
  always_comb
    state_n = !s_cyc ? IDLE :
              (state == IDLE) ? ((push | !empty) ? BUSY : IDLE) :
              (term & last & !push) ? IDLE : BUSY;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s_ack   <= 1'b0;
      s_dat_o <= '0;
    end else begin
      s_ack <= term & !err_in;
      if (term & !err_in) s_dat_o <= m_dat_i;
    end
`ifdef WB_BRIDGE_ERR_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) s_err <= 1'b0;
    else s_err <= term & err_in;
`endif
endmodule
